vram_sram_arbiter: RTL and testbench

Arbiter and sequencer for the single asynchronous 15-bit VRAM SRAM. It is shared between two requesters: the LCD refill reader (burst reads, high priority) and the spectrum pixel writer (single-word writes addressed by Screen/X/Y). It generates nWE/nOE/address/data-enable timing for the SRAM; the top level owns the tristate pad. It replaces ad-hoc SRAM sequencing inside the VRAM control path.

---
 rtl/vram_pkg.sv | 23 ++
 rtl/vram_sram_arbiter.sv | 128 ++++++++++++
 tb/tb_vram_sram_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM definitions: bus widths, arbiter state encoding and the
// screen/row/column to SRAM address map used by the writer and display scanner.
package vram_pkg;

  localparam int BW_ADDR = 18;
  localparam int BW_DATA = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ADDR   = 3'd1,
    ST_RD_SAMPLE = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5
  } arb_state_e;

  function automatic logic [BW_ADDR-1:0] map_xy(input logic screen,
                                                input logic [6:0] y,
                                                input logic [8:0] x);
    return {1'b0, screen, y, x};
  endfunction

endpackage

// File: rtl/vram_sram_arbiter.sv
// Arbitrates the asynchronous VRAM SRAM between the LCD burst reader (priority)
// and the pixel writer, and sequences nOE/nWE/address/data-enable for the pad.
module vram_sram_arbiter
  import vram_pkg::*;
#(
  parameter int RD_BURST = 320
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               RdReq,
  input  logic [BW_ADDR-1:0] RdAddr,
  output logic               RdBusy,
  output logic               RdValid,
  output logic [BW_DATA-1:0] RdData,
  input  logic               WrReq,
  input  logic               WrScreen,
  input  logic [8:0]         WrX,
  input  logic [6:0]         WrY,
  input  logic [BW_DATA-1:0] WrData,
  output logic               WrAck,
  output logic               nWE,
  output logic               nOE,
  output logic [BW_ADDR-1:0] SRAMAddr,
  output logic [BW_DATA-1:0] SRAMDout,
  output logic               SRAMDoe,
  input  logic [BW_DATA-1:0] SRAMDin
);

  localparam int CW = (RD_BURST > 1) ? $clog2(RD_BURST) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(RD_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [BW_ADDR-1:0] addr_q, addr_d;
  logic [BW_DATA-1:0] dout_q, dout_d;
  logic [BW_DATA-1:0] rd_data_q, rd_data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_busy_q, rd_busy_d;
  logic               wr_ack_q, wr_ack_d;
  logic               nwe_q, nwe_d;
  logic               noe_q, noe_d;
  logic               doe_q, doe_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RdReq) begin
          state_d = ST_RD_ADDR;
          addr_d  = RdAddr;
          cnt_d   = '0;
        end else if (WrReq) begin
          state_d = ST_WR_SETUP;
          addr_d  = map_xy(WrScreen, WrY, WrX);
          dout_d  = WrData;
        end
      end
      ST_RD_ADDR:   state_d = ST_RD_SAMPLE;
      ST_RD_SAMPLE: begin
        rd_data_d  = SRAMDin;
        rd_valid_d = 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_ADDR;
          addr_d  = addr_q + BW_ADDR'(1);
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_WR_SETUP:  state_d = ST_WR_STROBE;
      ST_WR_STROBE: state_d = ST_WR_HOLD;
      ST_WR_HOLD:   state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so the pad sees flop outputs.
    rd_busy_d = (state_d == ST_RD_ADDR) || (state_d == ST_RD_SAMPLE);
    noe_d     = !rd_busy_d;
    nwe_d     = (state_d != ST_WR_STROBE);
    doe_d     = (state_d == ST_WR_SETUP) || (state_d == ST_WR_STROBE) ||
                (state_d == ST_WR_HOLD);
    wr_ack_d  = (state_d == ST_WR_HOLD);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      dout_q     <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_busy_q  <= 1'b0;
      wr_ack_q   <= 1'b0;
      nwe_q      <= 1'b1;
      noe_q      <= 1'b1;
      doe_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_busy_q  <= rd_busy_d;
      wr_ack_q   <= wr_ack_d;
      nwe_q      <= nwe_d;
      noe_q      <= noe_d;
      doe_q      <= doe_d;
    end
  end

  assign RdBusy   = rd_busy_q;
  assign RdValid  = rd_valid_q;
  assign RdData   = rd_data_q;
  assign WrAck    = wr_ack_q;
  assign nWE      = nwe_q;
  assign nOE      = noe_q;
  assign SRAMAddr = addr_q;
  assign SRAMDout = dout_q;
  assign SRAMDoe  = doe_q;

endmodule

// File: tb/tb_vram_sram_arbiter.sv
// Directed and random-protocol bench for vram_sram_arbiter with a 4-word burst.
module tb_vram_sram_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        RdReq = 1'b0;
  logic [17:0] RdAddr = '0;
  logic        RdBusy, RdValid, WrAck, nWE, nOE, SRAMDoe;
  logic [14:0] RdData, SRAMDout, SRAMDin;
  logic        WrReq = 1'b0;
  logic        WrScreen = 1'b0;
  logic [8:0]  WrX = '0;
  logic [6:0]  WrY = '0;
  logic [14:0] WrData = '0;
  logic [17:0] SRAMAddr;

  int checks = 0;
  int errors = 0;

  vram_sram_arbiter #(.RD_BURST(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .RdReq(RdReq), .RdAddr(RdAddr), .RdBusy(RdBusy), .RdValid(RdValid), .RdData(RdData),
    .WrReq(WrReq), .WrScreen(WrScreen), .WrX(WrX), .WrY(WrY), .WrData(WrData), .WrAck(WrAck),
    .nWE(nWE), .nOE(nOE), .SRAMAddr(SRAMAddr), .SRAMDout(SRAMDout), .SRAMDoe(SRAMDoe),
    .SRAMDin(SRAMDin)
  );

  always #5 Clock = ~Clock;

  // SRAM model: drives the low address bits when output-enabled.
  assign SRAMDin = nOE ? 15'h2AAA : SRAMAddr[14:0];

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if ({nWE, nOE, SRAMDoe, RdBusy, RdValid, WrAck} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_strobes got=%b exp=110000", {nWE, nOE, SRAMDoe, RdBusy, RdValid, WrAck});
    end
    checks++;
    if (SRAMAddr !== 18'h0 || SRAMDout !== 15'h0 || RdData !== 15'h0) begin
      errors++;
      $display("FAIL reset_regs addr=%h dout=%h rddata=%h exp=0", SRAMAddr, SRAMDout, RdData);
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_write();
    logic [3:0] exp_nwe, exp_doe, exp_ack;
    exp_nwe = 4'b1011;  // cycle1..4, LSB-first listed as index c-1
    exp_nwe = {1'b1, 1'b1, 1'b0, 1'b1};
    exp_doe = {1'b0, 1'b1, 1'b1, 1'b1};
    exp_ack = {1'b0, 1'b1, 1'b0, 1'b0};
    WrScreen = 1'b1; WrX = 9'd5; WrY = 7'd3; WrData = 15'h1234; WrReq = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      checks++;
      if (nWE !== exp_nwe[c-1] || SRAMDoe !== exp_doe[c-1] || WrAck !== exp_ack[c-1] || nOE !== 1'b1) begin
        errors++;
        $display("FAIL write_c%0d nWE/Doe/Ack/nOE got=%b%b%b%b exp=%b%b%b1", c, nWE, SRAMDoe, WrAck, nOE,
                 exp_nwe[c-1], exp_doe[c-1], exp_ack[c-1]);
      end
      if (c <= 3) begin
        checks++;
        if (SRAMAddr !== 18'h10605 || SRAMDout !== 15'h1234) begin
          errors++;
          $display("FAIL write_bus_c%0d addr=%h dout=%h exp=10605/1234", c, SRAMAddr, SRAMDout);
        end
      end
      if (c == 3) WrReq = 1'b0;
    end
    @(negedge Clock);
    checks++;
    if (WrAck !== 1'b0 || SRAMDoe !== 1'b0) begin
      errors++;
      $display("FAIL write_idle ack=%b doe=%b exp=0/0", WrAck, SRAMDoe);
    end
  endtask

  // Observes one 4-word burst starting the cycle after RdReq is sampled.
  task automatic run_burst(input logic [17:0] base, input string nm);
    logic [17:0] ea;
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clock);
      if (c == 1) RdReq = 1'b0;
      checks++;
      if (RdBusy !== (c <= 8) || nOE !== !(c <= 8) || nWE !== 1'b1 || SRAMDoe !== 1'b0) begin
        errors++;
        $display("FAIL %s_ctl_c%0d busy=%b nOE=%b nWE=%b doe=%b exp busy=%b", nm, c, RdBusy, nOE, nWE,
                 SRAMDoe, (c <= 8));
      end
      checks++;
      if (RdValid !== (c >= 3 && c % 2 == 1)) begin
        errors++;
        $display("FAIL %s_valid_c%0d got=%b exp=%b", nm, c, RdValid, (c >= 3 && c % 2 == 1));
      end
      if (c % 2 == 1 && c <= 7) begin
        ea = base + 18'((c - 1) / 2);
        checks++;
        if (SRAMAddr !== ea) begin
          errors++;
          $display("FAIL %s_addr_c%0d got=%h exp=%h", nm, c, SRAMAddr, ea);
        end
      end
      if (c >= 3 && c % 2 == 1) begin
        ea = base + 18'((c - 3) / 2);
        checks++;
        if (RdData !== ea[14:0]) begin
          errors++;
          $display("FAIL %s_data_c%0d got=%h exp=%h", nm, c, RdData, ea[14:0]);
        end
      end
    end
  endtask

  task automatic test_burst();
    RdAddr = 18'h00100; RdReq = 1'b1;
    run_burst(18'h00100, "burst");
    @(negedge Clock);
  endtask

  task automatic test_wrap();
    RdAddr = 18'h3FFFE; RdReq = 1'b1;
    run_burst(18'h3FFFE, "wrap");
    @(negedge Clock);
  endtask

  task automatic test_simultaneous();
    RdAddr = 18'h00200; RdReq = 1'b1;
    WrScreen = 1'b0; WrX = 9'd17; WrY = 7'd100; WrData = 15'h5A5A; WrReq = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge Clock);
      if (c == 1) RdReq = 1'b0;
      checks++;
      if (WrAck !== (c == 12) || nWE !== (c != 11) || SRAMDoe !== (c >= 10 && c <= 12)) begin
        errors++;
        $display("FAIL simul_wr_c%0d ack=%b nWE=%b doe=%b", c, WrAck, nWE, SRAMDoe);
      end
      checks++;
      if (RdValid !== (c >= 3 && c <= 9 && c % 2 == 1)) begin
        errors++;
        $display("FAIL simul_valid_c%0d got=%b", c, RdValid);
      end
      if (c == 10) begin
        checks++;
        if (SRAMAddr !== {1'b0, 1'b0, 7'd100, 9'd17} || SRAMDout !== 15'h5A5A) begin
          errors++;
          $display("FAIL simul_wbus addr=%h dout=%h exp=%h/5a5a", SRAMAddr, SRAMDout,
                   {1'b0, 1'b0, 7'd100, 9'd17});
        end
      end
      if (c == 12) WrReq = 1'b0;
    end
  endtask

  task automatic test_reset_midburst();
    int seen;
    RdAddr = 18'h00040; RdReq = 1'b1;
    repeat (4) begin
      @(negedge Clock);
      RdReq = 1'b0;
    end
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if ({nWE, nOE, SRAMDoe, RdBusy, RdValid} !== 5'b11000) begin
      errors++;
      $display("FAIL midburst_reset got=%b exp=11000", {nWE, nOE, SRAMDoe, RdBusy, RdValid});
    end
    Reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge Clock);
      if (RdValid || RdBusy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midburst_after got=%0d cycles with valid/busy exp=0", seen);
    end
  endtask

  task automatic test_random_protocol();
    int issued, acks, bad_ack, viol_oe_we, viol_doe_oe, left;
    logic pending;
    issued = 0; acks = 0; bad_ack = 0; viol_oe_we = 0; viol_doe_oe = 0; pending = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge Clock);
      if (!nOE && !nWE) viol_oe_we++;
      if (SRAMDoe && !nOE) viol_doe_oe++;
      if (RdBusy) RdReq = 1'b0;
      else if ($urandom_range(0, 15) == 0) begin
        RdAddr = 18'($urandom);
        RdReq = 1'b1;
      end
      if (WrAck) begin
        if (!pending) bad_ack++;
        else acks++;
        pending = 1'b0;
        WrReq = 1'b0;
      end else if (!pending && $urandom_range(0, 3) == 0) begin
        WrScreen = 1'($urandom); WrX = 9'($urandom); WrY = 7'($urandom); WrData = 15'($urandom);
        WrReq = 1'b1; pending = 1'b1; issued++;
      end
    end
    RdReq = 1'b0;
    left = 100;
    while ((pending || RdBusy) && left > 0) begin
      @(negedge Clock);
      left--;
      if (!nOE && !nWE) viol_oe_we++;
      if (SRAMDoe && !nOE) viol_doe_oe++;
      if (WrAck) begin
        if (!pending) bad_ack++;
        else acks++;
        pending = 1'b0;
        WrReq = 1'b0;
      end
    end
    checks++;
    if (left == 0) begin
      errors++;
      $display("FAIL random_drain timeout pending=%b busy=%b", pending, RdBusy);
    end
    checks++;
    if (viol_oe_we !== 0 || viol_doe_oe !== 0) begin
      errors++;
      $display("FAIL random_strobes oe_we=%0d doe_oe=%0d exp=0/0", viol_oe_we, viol_doe_oe);
    end
    checks++;
    if (acks !== issued || bad_ack !== 0 || issued == 0) begin
      errors++;
      $display("FAIL random_acks issued=%0d acks=%0d spurious=%0d", issued, acks, bad_ack);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst();
    test_wrap();
    test_simultaneous();
    test_reset_midburst();
    test_random_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
